tap_window_avg: RTL and testbench
=================================

// Module: tap_window_avg
// PURPOSE
//  Downstream consumer of the 8-stage shift register (taps a..h, a = newest).
//  Forms the 8-tap window sum and mean once the window holds 8 valid samples,
//  through a 3-stage registered adder tree with a valid tag.
//  Flags when the mean exceeds a threshold. Driven by the same en as the shifter.
// PARAMETERS
//  WIDTH   16       tap/sample width, unsigned
//  THRESH  16'h8000 over flag asserts when avg > THRESH (strict)
// PORTS
//  clk    in   1        clock, rising edge
//  reset  in   1        asynchronous, active-low reset
//  en     in   1        shift enable, same signal/cycle as the shift register's en
//  clr    in   1        synchronous flush: window fill count and pipeline tags
//  a..h   in   WIDTH    shift-register taps; a newest, h oldest
//  sum    out  WIDTH+3  registered sum of a..h
//  avg    out  WIDTH    registered sum >> 3 (truncating)
//  valid  out  1        1-cycle strobe: sum/avg/over are valid this cycle
//  over   out  1        avg > THRESH; qualified by valid, else 0
//  full   out  1        window holds 8 samples since reset/clr
// BEHAVIOUR
//  Reset (reset==0, async): sum=0, avg=0, valid=0, over=0, full=0,
//   fill_cnt=0, en_d=0, all stage tags=0. Stage data registers are cleared.
//  Fill counter fill_cnt (0..8):
//   - edge with en=1, clr=0: fill_cnt+1, saturating at 8.
//   - full = (fill_cnt==8), registered.
//  Tap alignment: shifter updates taps on edge N when en=1, so taps are read at N+1.
//   - en_d <= en & ~clr.
//   - Edge N+1 with en_d=1: S1 captures pairwise sums (a+b, c+d, e+f, g+h; WIDTH+1 each).
//     tag1 = full as updated at N.
//  Pipeline:
//   - S2 at N+2: two WIDTH+2 sums, tag2 <= tag1.
//   - S3 at N+3: sum (WIDTH+3), avg = sum[WIDTH+2:3], valid = tag2,
//     over = tag2 & (avg_next > THRESH).
//  Latency: 3 cycles from the tap-update edge; a new sample each cycle is allowed.
//  Back-to-back en gives one valid per cycle. en gaps leave bubbles; tags clear behind them.
//  valid is a 1-cycle strobe. When valid=0, sum/avg hold their last value and over=0.
//  Windows with fewer than 8 samples (fill_cnt<8) never raise valid; the first valid
//   follows the 8th en.
//  No overflow: the WIDTH+3 sum covers 8*(2^WIDTH-1).
//  clr (sync):
//   - fill_cnt=0, full=0, en_d=0; tag1/tag2 and valid clear on the same edge.
//   - A valid scheduled for that edge is dropped.
//  clr and en on the same edge: clr wins. That shift is not counted (the shifter still
//   shifts); the count restarts on the next en.
//  Async reset mid-pipeline: all in-flight results are discarded; no valid after release
//   until 8 new en.
//  a..h are sampled only on en_d edges; changes at other times are ignored.
// TESTING
//  1 Reset then en every cycle, din=1..8 -> first valid 3 cycles after the edge of the 8th tap
//    update, sum=36, avg=4, over=0; full rises after 8th en.
//  2 Continue din=9,10.. back-to-back -> valid every cycle, sum 44,52,60.. (+8 each), avg 5,6,7..
//  3 Fill with din=16'hFFFF x8 -> sum=19'h7FFF8, avg=16'hFFFF, over=1.
//    Then 8x 16'h8000 -> avg=16'h8000, over=0 (strict >).
//  4 en high only every 3rd cycle, din=2 -> valid exactly 3 cycles after each shift,
//    sum=16, avg=2; valid=0 elsewhere.
//  5 clr asserted with en on the 5th sample -> full=0, no valid for that window;
//    next valid only after 8 further en; an in-flight valid at clr edge suppressed.
//  6 reset pulsed low while valid pipeline full -> outputs 0 immediately (async);
//    after release, 7 en give no valid, 8th gives valid.

Source files
------------

// File: rtl/tap_window_avg.sv
// tap_window_avg: 8-tap window sum/mean over a shift register's taps.
// A fill counter tracks how many samples the window holds. A 3-stage registered
// adder tree carries a valid tag, so only full windows produce a result strobe.
// The over flag compares the mean against THRESH (strictly greater).
module tap_window_avg #(
  parameter int                WIDTH  = 16,
  parameter logic [WIDTH-1:0]  THRESH = 16'h8000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]   e,
  input  logic [WIDTH-1:0]   f,
  input  logic [WIDTH-1:0]   g,
  input  logic [WIDTH-1:0]   h,
  output logic [WIDTH+2:0]   sum,
  output logic [WIDTH-1:0]   avg,
  output logic               valid,
  output logic               over,
  output logic               full
);

  logic [3:0]       fill_cnt_r;
  logic [3:0]       fill_cnt_s;
  logic             full_r;
  logic             en_d_r;
  logic [WIDTH:0]   s1_ab_r, s1_cd_r, s1_ef_r, s1_gh_r;
  logic             tag1_r;
  logic [WIDTH+1:0] s2_lo_r, s2_hi_r;
  logic             tag2_r;
  logic [WIDTH+2:0] sum_r;
  logic [WIDTH-1:0] avg_r;
  logic             valid_r;
  logic             over_r;
  logic [WIDTH+2:0] sum_s;
  logic [WIDTH-1:0] avg_s;
  logic             over_s;

  // Next fill count: clr restarts the count, en advances it up to 8.
  always_comb begin
    fill_cnt_s = fill_cnt_r;
    if (clr) begin
      fill_cnt_s = 4'd0;
    end else if (en && (fill_cnt_r != 4'd8)) begin
      fill_cnt_s = fill_cnt_r + 4'd1;
    end else begin
      fill_cnt_s = fill_cnt_r;
    end
  end

  // Final adder stage and threshold compare on the value about to be registered.
  always_comb begin
    sum_s  = {1'b0, s2_lo_r} + {1'b0, s2_hi_r};
    avg_s  = sum_s[WIDTH+2:3];
    over_s = 1'b0;
    if (tag2_r && (avg_s > THRESH)) begin
      over_s = 1'b1;
    end else begin
      over_s = 1'b0;
    end
  end

  // Fill tracking and the one-cycle en delay that lines up with the shifted taps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt_r <= 4'd0;
      full_r     <= 1'b0;
      en_d_r     <= 1'b0;
    end else begin
      fill_cnt_r <= fill_cnt_s;
      full_r     <= (fill_cnt_s == 4'd8);
      en_d_r     <= en & ~clr;
    end
  end

  // Stage 1: pairwise sums of the freshly shifted taps; tag marks a full window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_ab_r <= '0;
      s1_cd_r <= '0;
      s1_ef_r <= '0;
      s1_gh_r <= '0;
      tag1_r  <= 1'b0;
    end else begin
      if (en_d_r) begin
        s1_ab_r <= {1'b0, a} + {1'b0, b};
        s1_cd_r <= {1'b0, c} + {1'b0, d};
        s1_ef_r <= {1'b0, e} + {1'b0, f};
        s1_gh_r <= {1'b0, g} + {1'b0, h};
      end
      tag1_r <= en_d_r & full_r & ~clr;
    end
  end

  // Stage 2: two quad sums; data only moves when a tagged result is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_lo_r <= '0;
      s2_hi_r <= '0;
      tag2_r  <= 1'b0;
    end else begin
      if (tag1_r) begin
        s2_lo_r <= {1'b0, s1_ab_r} + {1'b0, s1_cd_r};
        s2_hi_r <= {1'b0, s1_ef_r} + {1'b0, s1_gh_r};
      end
      tag2_r <= tag1_r & ~clr;
    end
  end

  // Stage 3: registered outputs; sum/avg hold between strobes, clr drops a pending strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_r   <= '0;
      avg_r   <= '0;
      valid_r <= 1'b0;
      over_r  <= 1'b0;
    end else begin
      if (tag2_r) begin
        sum_r <= sum_s;
        avg_r <= avg_s;
      end
      valid_r <= tag2_r & ~clr;
      over_r  <= over_s & ~clr;
    end
  end

  assign sum   = sum_r;
  assign avg   = avg_r;
  assign valid = valid_r;
  assign over  = over_r;
  assign full  = full_r;

endmodule

// File: tb/tb_tap_window_avg.sv
// Directed self-checking bench for tap_window_avg. A behavioural 8-stage
// shifter feeds the taps; expected sums/means are hand-computed per scenario.
module tb_tap_window_avg;

  logic        clk;
  logic        reset;
  logic        en;
  logic        clr;
  logic [15:0] din;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [18:0] sum;
  logic [15:0] avg;
  logic        valid;
  logic        over;
  logic        full;

  int checks;
  int errors;

  tap_window_avg dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .sum(sum), .avg(avg), .valid(valid), .over(over), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream shift register: shifts on en regardless of clr, cleared by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      {a, b, c, d, e, f, g, h} <= '0;
    end else if (en) begin
      a <= din; b <= a; c <= b; d <= c; e <= d; f <= e; g <= f; h <= g;
    end
  end

  // One clock: drive inputs away from the edge, then settle 1 time unit past it.
  task automatic tick(input logic en_v, input logic [15:0] din_v, input logic clr_v);
    en = en_v; din = din_v; clr = clr_v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; en = 1'b0; clr = 1'b0; din = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sum !== 19'd0)   begin errors++; $display("FAIL reset_sum got %0h exp 0", sum); end
    checks++; if (avg !== 16'd0)   begin errors++; $display("FAIL reset_avg got %0h exp 0", avg); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (over !== 1'b0)   begin errors++; $display("FAIL reset_over got %b exp 0", over); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    reset = 1'b1;
    tick(1'b0, 16'd0, 1'b0);
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 16'(i), 1'b0);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fill_valid[%0d] got %b exp 0", i, valid); end
      checks++; if (full !== (i == 8)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 8)); end
    end
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 16'd0, 1'b0);
      checks++; if (valid !== (k == 3)) begin errors++; $display("FAIL fill_lat[%0d] got %b exp %b", k, valid, (k == 3)); end
    end
    checks++; if (sum !== 19'd36) begin errors++; $display("FAIL fill_sum got %0d exp 36", sum); end
    checks++; if (avg !== 16'd4)  begin errors++; $display("FAIL fill_avg got %0d exp 4", avg); end
    checks++; if (over !== 1'b0)  begin errors++; $display("FAIL fill_over got %b exp 0", over); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 7; i++) begin
      tick(i < 4, 16'(9 + i), 1'b0);
      checks++; if (valid !== (i >= 3)) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, valid, (i >= 3)); end
      if (i >= 3) begin
        checks++; if (sum !== 19'(44 + 8 * (i - 3))) begin errors++; $display("FAIL b2b_sum[%0d] got %0d exp %0d", i, sum, 44 + 8 * (i - 3)); end
        checks++; if (avg !== 16'(5 + (i - 3))) begin errors++; $display("FAIL b2b_avg[%0d] got %0d exp %0d", i, avg, 5 + (i - 3)); end
      end
    end
  endtask

  task automatic test_thresh;
    for (int i = 0; i < 8; i++) tick(1'b1, 16'hFFFF, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 16'd0, 1'b0);
    checks++; if (valid !== 1'b1)      begin errors++; $display("FAIL max_valid got %b exp 1", valid); end
    checks++; if (sum !== 19'h7FFF8)   begin errors++; $display("FAIL max_sum got %0h exp 7fff8", sum); end
    checks++; if (avg !== 16'hFFFF)    begin errors++; $display("FAIL max_avg got %0h exp ffff", avg); end
    checks++; if (over !== 1'b1)       begin errors++; $display("FAIL max_over got %b exp 1", over); end
    for (int i = 0; i < 8; i++) tick(1'b1, 16'h8000, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 16'd0, 1'b0);
    checks++; if (valid !== 1'b1)      begin errors++; $display("FAIL eq_valid got %b exp 1", valid); end
    checks++; if (sum !== 19'h40000)   begin errors++; $display("FAIL eq_sum got %0h exp 40000", sum); end
    checks++; if (avg !== 16'h8000)    begin errors++; $display("FAIL eq_avg got %0h exp 8000", avg); end
    checks++; if (over !== 1'b0)       begin errors++; $display("FAIL eq_over got %b exp 0", over); end
    tick(1'b0, 16'd0, 1'b0);
    checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL strobe_width got %b exp 0", valid); end
    checks++; if (over !== 1'b0)       begin errors++; $display("FAIL over_unqual got %b exp 0", over); end
    checks++; if (avg !== 16'h8000)    begin errors++; $display("FAIL avg_hold got %0h exp 8000", avg); end
  endtask

  task automatic test_gaps;
    logic exp_v;
    tick(1'b0, 16'd0, 1'b1);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL gap_clr_full got %b exp 0", full); end
    for (int i = 0; i < 39; i++) begin
      tick((i % 3 == 0) && (i < 36), 16'd2, 1'b0);
      exp_v = (i % 3 == 0) && (i >= 24) && (i <= 36);
      checks++; if (valid !== exp_v) begin errors++; $display("FAIL gap_valid[%0d] got %b exp %b", i, valid, exp_v); end
      if (exp_v) begin
        checks++; if (sum !== 19'd16) begin errors++; $display("FAIL gap_sum[%0d] got %0d exp 16", i, sum); end
        checks++; if (avg !== 16'd2)  begin errors++; $display("FAIL gap_avg[%0d] got %0d exp 2", i, avg); end
      end
      if (i == 18 || i == 21) begin
        checks++; if (full !== (i == 21)) begin errors++; $display("FAIL gap_full[%0d] got %b exp %b", i, full, (i == 21)); end
      end
    end
  endtask

  task automatic test_clr;
    for (int i = 0; i < 4; i++) tick(1'b1, 16'd3, 1'b0);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid got %b exp 1", valid); end
    checks++; if (sum !== 19'd17) begin errors++; $display("FAIL clr_pre_sum got %0d exp 17", sum); end
    tick(1'b1, 16'd3, 1'b1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clr_drop got %b exp 0", valid); end
    checks++; if (full !== 1'b0)  begin errors++; $display("FAIL clr_full got %b exp 0", full); end
    for (int i = 0; i < 11; i++) begin
      tick(i < 8, 16'd3, 1'b0);
      checks++; if (valid !== (i == 10)) begin errors++; $display("FAIL clr_refill[%0d] got %b exp %b", i, valid, (i == 10)); end
      if (i == 6 || i == 7) begin
        checks++; if (full !== (i == 7)) begin errors++; $display("FAIL clr_full[%0d] got %b exp %b", i, full, (i == 7)); end
      end
    end
    checks++; if (sum !== 19'd24) begin errors++; $display("FAIL clr_sum got %0d exp 24", sum); end
    checks++; if (avg !== 16'd3)  begin errors++; $display("FAIL clr_avg got %0d exp 3", avg); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 4; i++) tick(1'b1, 16'd5, 1'b0);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b exp 1", valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", valid); end
    checks++; if (sum !== 19'd0)  begin errors++; $display("FAIL ar_sum got %0d exp 0", sum); end
    checks++; if (avg !== 16'd0)  begin errors++; $display("FAIL ar_avg got %0d exp 0", avg); end
    checks++; if (full !== 1'b0)  begin errors++; $display("FAIL ar_full got %b exp 0", full); end
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(i < 7, 16'd5, 1'b0);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ar_seven[%0d] got %b exp 0", i, valid); end
    end
    tick(1'b1, 16'd5, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 16'd0, 1'b0);
      checks++; if (valid !== (k == 3)) begin errors++; $display("FAIL ar_eighth[%0d] got %b exp %b", k, valid, (k == 3)); end
    end
    checks++; if (sum !== 19'd40) begin errors++; $display("FAIL ar_sum8 got %0d exp 40", sum); end
    checks++; if (avg !== 16'd5)  begin errors++; $display("FAIL ar_avg8 got %0d exp 5", avg); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_thresh();
    test_gaps();
    test_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
